// File: rtl/led_scan_if.sv
// Bundle between the 7-segment scanner and whatever drives or observes it.
// The driver side loads a value and decimal points; the scanner side returns
// the nibble for the segment decoder, the digit enables and the frame pulse.
interface led_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] VALUE;
    logic [DIGITS-1:0]   DP_IN;
    logic                LOAD;
    logic                BLANK_ZERO;
    logic [3:0]          NIBBLE;
    logic [DIGITS-1:0]   DIG_N;
    logic                DP_N;
    logic                FRAME;

    modport master (
        output VALUE, DP_IN, LOAD, BLANK_ZERO,
        input  NIBBLE, DIG_N, DP_N, FRAME
    );

    modport slave (
        input  VALUE, DP_IN, LOAD, BLANK_ZERO,
        output NIBBLE, DIG_N, DP_N, FRAME
    );
endinterface

// File: rtl/led_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment bank.
// Each digit gets PRESCALE cycles: BLANK cycles with every digit off, so the
// decoder settles without ghosting, then the digit is enabled. New values sit
// in a pending register and are only committed at the frame wrap, so a frame
// never mixes old and new digits. Every output is registered and loaded from
// the next-state decode, which keeps it aligned with the counters in the same
// clock period and free of combinational glitches.
module led_scan #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic      CLK,
    input  logic      RST_N,
    led_scan_if.slave bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DW-1:0]             dig_q, dig_d;
    logic [DIGITS-1:0][3:0]    disp_v_q, disp_v_d, pend_v_q;
    logic [DIGITS-1:0]         disp_dp_q, disp_dp_d, pend_dp_q;
    logic                      pv_q, pv_d;
    logic                      cnt_wrap, frame_wrap, commit;

    logic [3:0]                nibble_q, nibble_d;
    logic [DIGITS-1:0]         dig_n_q, dig_n_d;
    logic                      dp_n_q, dp_n_d;
    logic                      frame_q;

    logic [DIGITS:0]           zf;     // zf[d]: digits d..DIGITS-1 blank (nibble 0, no dp)
    logic                      sup, show;

    // Slot/digit counters and the frame-boundary commit of the pending value.
    always_comb begin
        cnt_wrap   = (cnt_q == CW'(PRESCALE - 1));
        frame_wrap = cnt_wrap && (dig_q == DW'(DIGITS - 1));
        cnt_d      = cnt_wrap ? '0 : cnt_q + CW'(1);
        dig_d      = dig_q;
        if (cnt_wrap)
            dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + DW'(1);
        commit     = frame_wrap && pv_q;
        disp_v_d   = disp_v_q;
        disp_dp_d  = disp_dp_q;
        if (commit) begin
            disp_v_d  = pend_v_q;
            disp_dp_d = pend_dp_q;
        end
        // A LOAD on the commit edge re-arms PV for the next frame.
        pv_d = bus.LOAD ? 1'b1 : (commit ? 1'b0 : pv_q);
    end

    // Leading-zero suppression, evaluated on the display contents that will
    // be in effect next period; BLANK_ZERO is taken live.
    always_comb begin
        zf[DIGITS] = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--)
            zf[d] = zf[d+1] && (disp_v_d[d] == 4'h0) && !disp_dp_d[d];
        sup = 1'b0;
        for (int d = 1; d < DIGITS; d++)
            if (dig_d == DW'(d))
                sup = bus.BLANK_ZERO && zf[d];
    end

    // Output decode from next state; nibble is presented through the blank phase.
    always_comb begin
        show     = (cnt_d >= CW'(BLANK));
        nibble_d = disp_v_d[dig_d];
        dig_n_d  = '1;
        dp_n_d   = 1'b1;
        if (show && !sup) begin
            dig_n_d[dig_d] = 1'b0;
            dp_n_d         = ~disp_dp_d[dig_d];
        end
    end

    // State and registered outputs; reset discards any pending load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            disp_v_q  <= '0;
            disp_dp_q <= '0;
            pend_v_q  <= '0;
            pend_dp_q <= '0;
            pv_q      <= 1'b0;
            nibble_q  <= 4'h0;
            dig_n_q   <= '1;
            dp_n_q    <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            disp_v_q  <= disp_v_d;
            disp_dp_q <= disp_dp_d;
            pv_q      <= pv_d;
            if (bus.LOAD) begin
                pend_v_q  <= bus.VALUE;
                pend_dp_q <= bus.DP_IN;
            end
            nibble_q  <= nibble_d;
            dig_n_q   <= dig_n_d;
            dp_n_q    <= dp_n_d;
            frame_q   <= frame_wrap;
        end
    end

    assign bus.NIBBLE = nibble_q;
    assign bus.DIG_N  = dig_n_q;
    assign bus.DP_N   = dp_n_q;
    assign bus.FRAME  = frame_q;
endmodule

// File: doc/led_scan.md
Name: led_scan

Overview:
- Time-multiplexed scanner for the motherboard's common-anode 7-segment display bank.
- Holds a multi-digit hex value and presents one 4-bit nibble at a time to the downstream nibble-to-segment decoder (LED block, IN port).
- Drives the active-low digit enables and the active-low decimal point directly.
- Top level forms the segment bus as {decoder OUT[7:1], DP_N}; decoder OUT[0] is unused.

Parameters:
- DIGITS, 4, number of digits scanned; digit 0 = least significant nibble.
- PRESCALE, 1000, clock cycles per digit slot; legal values ≥ 2.
- BLANK, 16, cycles at the start of each slot with all digits off (anti-ghosting); legal values 1 ≤ BLANK < PRESCALE.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset. Asserting it forces reset values immediately; release is synchronous to CLK.
- VALUE  in  4*DIGITS  value to display; nibble d = VALUE[4d+3:4d].
- DP_IN  in  DIGITS  decimal point request per digit, 1 = lit.
- LOAD  in  1  capture VALUE and DP_IN into the pending register on this edge.
- BLANK_ZERO  in  1  leading-zero suppression enable; sampled live, not captured by LOAD.
- NIBBLE  out  4  nibble of the current digit; feeds LED.IN.
- DIG_N  out  DIGITS  active-low one-cold digit enable.
- DP_N  out  1  active-low decimal point for the current digit.
- FRAME  out  1  one-cycle pulse at the start of each frame.

Behaviour:

State:
- Slot counter CNT: 0..PRESCALE-1.
- Digit index DIG: 0..DIGITS-1.
- Display register DISP (value + dp).
- Pending register PEND (value + dp) with valid flag PV.
- All outputs are registered. Each output register is loaded from the next-state decode, so output values align with the CNT/DIG registers in the same clock period, with no combinational glitches.

Reset values:
- CNT=0, DIG=0, DISP=0, PEND=0, PV=0.
- NIBBLE=0, DIG_N=all ones, DP_N=1, FRAME=0.

Scan sequence:
- Each edge: CNT increments. At CNT=PRESCALE-1 it wraps to 0 and DIG advances; DIG=DIGITS-1 wraps to 0.
- Phase BLANK (CNT < BLANK): DIG_N = all ones, DP_N = 1.
- Phase SHOW (CNT ≥ BLANK): DIG_N[DIG]=0 and all other bits 1, unless DIG is suppressed. DP_N = ~DISP.dp[DIG]; forced to 1 if the digit is suppressed.
- NIBBLE = DISP nibble[DIG] for the whole slot, including the blank phase, so the decoder settles before the digit enables.

Leading-zero suppression:
- Applies only when BLANK_ZERO=1.
- Digit d > 0 is suppressed iff DISP nibbles d..DIGITS-1 are all zero and their DISP dp bits are all zero.
- Digit 0 is never suppressed.

Load and commit:
- LOAD=1: PEND ← {VALUE, DP_IN}, PV ← 1.
- Commit: on the edge where DIG wraps DIGITS-1→0 (CNT also wrapping), if PV=1 then DISP ← PEND and PV ← 0. DISP never changes mid-frame, so there is no tearing.
- LOAD on the commit edge: the commit uses the PEND contents from before that edge. The new capture lands in PEND with PV=1 and is committed at the next frame.
- Multiple LOADs within one frame: last one wins.

FRAME:
- 1 for exactly the clock period following each DIGITS-1→0 wrap.
- Not asserted in the post-reset period.

Reset mid-slot or mid-frame:
- Everything returns to reset values.
- A pending load is discarded.

Test Plan:
1. Reset and timing (PRESCALE=8, BLANK=2, DIGITS=4; release RST_N, LOAD held 0): DIG_N=4'b1111 for 2 cycles, 4'b1110 for 6, 4'b1111 for 2, then 4'b1101. FRAME first pulses 32 cycles after release; NIBBLE=0 throughout.
2. Load and commit (same parameters; LOAD with VALUE=16'h1234 at cycle 5): DISP unchanged until the first frame wrap. From then NIBBLE=4,3,2,1 in slots 0..3, and DIG_N low only in SHOW cycles.
3. Suppression (BLANK_ZERO=1, commit VALUE=16'h00A5, DP_IN=0): DIG_N[3] and DIG_N[2] stay 1 for a whole frame; slot 1 NIBBLE=A; slot 0 NIBBLE=5. Commit VALUE=0: only DIG_N[0] ever goes low, NIBBLE=0. Set DP_IN=4'b0100 with VALUE=0: digit 2 is shown with DP_N=0.
4. LOAD collision (LOAD VALUE=16'hBEEF on the commit edge, PV=0): DISP unchanged that frame; 16'hBEEF displayed from the following frame. Two LOADs in one frame (16'h1111 then 16'h2222): only 16'h2222 appears.
5. Async reset (assert RST_N low mid-SHOW of digit 2 with DISP=16'h1234): DIG_N=4'b1111 and DP_N=1 immediately without a clock edge. After release, the scan restarts at digit 0 with NIBBLE=0.
6. DP (commit DP_IN=4'b0001, VALUE=16'h5678, BLANK_ZERO=0): DP_N=0 only during slot-0 SHOW cycles; DP_N=1 in all BLANK cycles and in every other slot.
